// File: rtl/sr_lifo_pkg.sv
// Shared definitions for the sr_lifo stack: default geometry and the op encoding
// used by the next-state decode.
package sr_lifo_pkg;

  localparam int LIFO_DEFAULT_WIDTH = 32;
  localparam int LIFO_DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    LIFO_OP_NONE = 2'b00,
    LIFO_OP_POP  = 2'b01,
    LIFO_OP_PUSH = 2'b10,
    LIFO_OP_REPL = 2'b11
  } lifo_op_e;

  // Flush wins over any push/pop request in the same cycle.
  function automatic lifo_op_e lifo_decode_op(input logic flush, input logic push,
                                              input logic pop);
    lifo_op_e op;
    op = LIFO_OP_NONE;
    if (!flush) begin
      unique case ({push, pop})
        2'b10:   op = LIFO_OP_PUSH;
        2'b01:   op = LIFO_OP_POP;
        2'b11:   op = LIFO_OP_REPL;
        default: op = LIFO_OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/sr_lifo_mem.sv
// DEPTH x WIDTH stack storage: one synchronous write port, two asynchronous read
// ports (TOS and next-on-stack). Contents are deliberately not reset.
module sr_lifo_mem #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd0_data = mem_q[rd0_addr];
  assign rd1_data = mem_q[rd1_addr];

endmodule

// File: rtl/sr_lifo.sv
// Parametrised LIFO stack with replace-top, next-on-stack read, count and flush.
// Define SR_LIFO_ERR_EN to add sticky overflow/underflow flags and err_clr.
module sr_lifo
  import sr_lifo_pkg::*;
#(
  parameter  int WIDTH = LIFO_DEFAULT_WIDTH,
  parameter  int DEPTH = LIFO_DEFAULT_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_nos,
  output logic             empty,
  output logic             full,
`ifdef SR_LIFO_ERR_EN
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr,
`endif
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    tos_addr, nos_addr;
  logic [WIDTH-1:0] tos_data, nos_data;
  logic             has_tos, has_nos;
  logic             ovf_set, unf_set;
  lifo_op_e         op;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign has_tos = !empty;
  assign has_nos = (count_q >= CW'(2));
  assign count   = count_q;

  // Read addresses are forced to 0 when the slot does not exist so a non-power-of-two
  // DEPTH never sees an out-of-range index.
  assign tos_addr = has_tos ? AW'(count_q - CW'(1)) : '0;
  assign nos_addr = has_nos ? AW'(count_q - CW'(2)) : '0;

  assign op = lifo_decode_op(flush, push, pop);

  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case (op)
        LIFO_OP_PUSH: begin
          if (!full) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q);
            count_d = count_q + CW'(1);
          end else begin
            ovf_set = 1'b1;
          end
        end
        LIFO_OP_POP: begin
          if (!empty) begin
            count_d = count_q - CW'(1);
          end else begin
            unf_set = 1'b1;
          end
        end
        LIFO_OP_REPL: begin
          // Replace-top is legal at full; on an empty stack it degrades to a push
          // but the missing pop is still reported.
          wr_en = 1'b1;
          if (!empty) begin
            wr_addr = tos_addr;
          end else begin
            wr_addr = '0;
            count_d = CW'(1);
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  sr_lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (din),
    .rd0_addr (tos_addr),
    .rd0_data (tos_data),
    .rd1_addr (nos_addr),
    .rd1_data (nos_data)
  );

  assign dout     = has_tos ? tos_data : '0;
  assign dout_nos = has_nos ? nos_data : '0;

`ifdef SR_LIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A same-cycle error event beats err_clr.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_set) overflow_d = 1'b1;
    if (unf_set) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err;
  assign unused_err = ovf_set ^ unf_set;
`endif

endmodule

// File: tb/tb_sr_lifo.sv
// Directed self-checking bench for sr_lifo at WIDTH=8, DEPTH=4; flag checks are
// active when SR_LIFO_ERR_EN is defined.
module tb_sr_lifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_nos;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
`ifdef SR_LIFO_ERR_EN
  logic             overflow;
  logic             underflow;
  logic             err_clr;
`endif

  int checks = 0;
  int errors = 0;

  sr_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .din       (din),
    .dout      (dout),
    .dout_nos  (dout_nos),
    .empty     (empty),
    .full      (full),
`ifdef SR_LIFO_ERR_EN
    .overflow  (overflow),
    .underflow (underflow),
    .err_clr   (err_clr),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock: apply request, take the edge, sample 1 time unit later, go idle.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic f);
    push  = p;
    pop   = q;
    din   = d;
    flush = f;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int exp_count, input logic [7:0] exp_dout,
                           input logic [7:0] exp_nos);
    chk({tag, "_count"}, 32'(count), 32'(exp_count));
    chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    chk({tag, "_nos"}, 32'(dout_nos), 32'(exp_nos));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_count == 0));
    chk({tag, "_full"}, 32'(full), 32'(exp_count == DEPTH));
  endtask

`ifdef SR_LIFO_ERR_EN
  task automatic chk_flags(input string tag, input logic exp_ovf, input logic exp_unf);
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
  endtask
`endif

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
`ifdef SR_LIFO_ERR_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("reset", 0, 8'h00, 8'h00);
`ifdef SR_LIFO_ERR_EN
    chk_flags("reset", 1'b0, 1'b0);
`endif

    // Fill
    step(1'b1, 1'b0, 8'h11, 1'b0); chk_state("push1", 1, 8'h11, 8'h00);
    step(1'b1, 1'b0, 8'h22, 1'b0); chk_state("push2", 2, 8'h22, 8'h11);
    step(1'b1, 1'b0, 8'h33, 1'b0); chk_state("push3", 3, 8'h33, 8'h22);
    step(1'b1, 1'b0, 8'h44, 1'b0); chk_state("push4", 4, 8'h44, 8'h33);

    // Overflow: push dropped
    step(1'b1, 1'b0, 8'h55, 1'b0); chk_state("ovf", 4, 8'h44, 8'h33);
`ifdef SR_LIFO_ERR_EN
    chk_flags("ovf", 1'b1, 1'b0);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk_flags("errclr", 1'b0, 1'b0);
`endif

    // Replace at full: accepted, no overflow
    step(1'b1, 1'b1, 8'h99, 1'b0); chk_state("repl_full", 4, 8'h99, 8'h33);
`ifdef SR_LIFO_ERR_EN
    chk_flags("repl_full", 1'b0, 1'b0);
`endif

    // Drain
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("pop1", 3, 8'h33, 8'h22);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("pop2", 2, 8'h22, 8'h11);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("pop3", 1, 8'h11, 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("pop4", 0, 8'h00, 8'h00);

    // Underflow from reset
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("unf", 0, 8'h00, 8'h00);
`ifdef SR_LIFO_ERR_EN
    chk_flags("unf", 1'b0, 1'b1);
`endif
    step(1'b1, 1'b1, 8'h77, 1'b0); chk_state("repl_empty", 1, 8'h77, 8'h00);
`ifdef SR_LIFO_ERR_EN
    chk_flags("repl_empty", 1'b0, 1'b1);
`endif
    step(1'b0, 1'b1, 8'h00, 1'b0); chk_state("pop_last", 0, 8'h00, 8'h00);
`ifdef SR_LIFO_ERR_EN
    // Error event and err_clr in the same cycle: flag stays set
    err_clr = 1'b1;
    step(1'b0, 1'b1, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk_flags("clr_vs_err", 1'b0, 1'b1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    chk_flags("clr_unf", 1'b0, 1'b0);
`endif

    // Replace top mid-stack
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0); chk_state("repl_mid", 2, 8'h99, 8'h11);

    // Flush beats push
    step(1'b1, 1'b0, 8'h33, 1'b0); chk_state("pre_flush", 3, 8'h33, 8'h99);
    step(1'b1, 1'b0, 8'hAA, 1'b1); chk_state("flush", 0, 8'h00, 8'h00);
`ifdef SR_LIFO_ERR_EN
    chk_flags("flush", 1'b0, 1'b0);
`endif

    // Async reset between edges during a push burst
    step(1'b1, 1'b0, 8'h01, 1'b0);
    step(1'b1, 1'b0, 8'h02, 1'b0);
    step(1'b1, 1'b0, 8'h03, 1'b0); chk_state("burst", 3, 8'h03, 8'h02);
    push = 1'b1;
    din  = 8'h04;
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst", 0, 8'h00, 8'h00);
    push = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h5A, 1'b0); chk_state("post_rst", 1, 8'h5A, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
